// File: rtl/rr_alloc.sv
// rr_alloc: writer side of the spare-row compare path.
//
// New pivot fault rows arrive one at a time. Each row is compared against
// the spare-row entries already allocated. A row that matches nothing is
// written to the next free entry. A row that matches nothing while all four
// entries are taken raises a sticky repair-failure flag.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   clear     synchronous flush, same effect as rst
//   np_valid  request valid
//   np_ready  request can be accepted this cycle (state-decoded)
//   np_row    request {block, addr}
//   np_local  RLSS value stored with the row if it is allocated
//   rrx1..4   stored entries 0..3, each {block, addr}
//   rlss      per-entry RLSS (1: compare block+addr, 0: addr only)
//   rr_valid  per-entry occupied flag
//   rr_count  number of occupied entries, 0..4
//   hit       one-cycle pulse, request matched an existing entry
//   alloc     one-cycle pulse, request written to a new entry
//   fail      sticky, unmatched request arrived while full
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready; latches an accepted request
// CHECK | one cycle comparing the latched row against stored entries
// FAIL  | table was full on a miss; requests accepted and discarded

module rr_alloc #(
  parameter int ADDR_W = 10,
  parameter int BLK_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     np_valid,
  output logic                     np_ready,
  input  logic [BLK_W+ADDR_W-1:0]  np_row,
  input  logic                     np_local,
  output logic [BLK_W+ADDR_W-1:0]  rrx1,
  output logic [BLK_W+ADDR_W-1:0]  rrx2,
  output logic [BLK_W+ADDR_W-1:0]  rrx3,
  output logic [BLK_W+ADDR_W-1:0]  rrx4,
  output logic [3:0]               rlss,
  output logic [3:0]               rr_valid,
  output logic [2:0]               rr_count,
  output logic                     hit,
  output logic                     alloc,
  output logic                     fail
);

  localparam int ENT_W = BLK_W + ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_FAIL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   req_row_q;
  logic               req_local_q;
  logic [ENT_W-1:0]   ent_q [4];
  logic [3:0]         rlss_q;
  logic [3:0]         valid_q;
  logic [2:0]         count_q;
  logic               hit_q;
  logic               alloc_q;
  logic               fail_q;
  logic               wr_pend_q;

  logic               flush;
  logic               accept;
  logic [3:0]         match;
  logic               any_match;
  logic               full;
  logic               in_check;

  assign flush     = rst | clear;
  assign accept    = np_valid & np_ready;
  assign in_check  = (state_q == S_CHECK);
  assign full      = (count_q == 3'd4);
  assign any_match = |match;

  // Only the stored entry's RLSS decides whether the block field takes part.
  always_comb begin
    match = '0;
    for (int i = 0; i < 4; i++) begin
      match[i] = valid_q[i]
              && (ent_q[i][ADDR_W-1:0] == req_row_q[ADDR_W-1:0])
              && (!rlss_q[i] || (ent_q[i][ENT_W-1:ADDR_W] == req_row_q[ENT_W-1:ADDR_W]));
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (flush) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CHECK;
      S_CHECK: state_d = (any_match || !full) ? S_IDLE : S_FAIL;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    np_ready = 1'b0;
    case (state_q)
      S_IDLE:  np_ready = 1'b1;
      S_FAIL:  np_ready = 1'b1;
      default: np_ready = 1'b0;
    endcase
  end

  // Datapath. The entry write is staged one cycle behind the alloc pulse;
  // req_row_q is still intact then because a new request can only be
  // latched on that same edge, and the nonblocking update uses the old copy.
  always_ff @(posedge clk) begin
    if (flush) begin
      req_row_q   <= '0;
      req_local_q <= 1'b0;
      for (int i = 0; i < 4; i++) ent_q[i] <= '0;
      rlss_q      <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      hit_q       <= 1'b0;
      alloc_q     <= 1'b0;
      fail_q      <= 1'b0;
      wr_pend_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && accept) begin
        req_row_q   <= np_row;
        req_local_q <= np_local;
      end
      hit_q     <= in_check && any_match;
      alloc_q   <= in_check && !any_match && !full;
      wr_pend_q <= in_check && !any_match && !full;
      if (in_check && !any_match && full) fail_q <= 1'b1;
      // Entries only ever fill, so the lowest free index is the count.
      if (wr_pend_q) begin
        ent_q[count_q[1:0]]   <= req_row_q;
        rlss_q[count_q[1:0]]  <= req_local_q;
        valid_q[count_q[1:0]] <= 1'b1;
        count_q               <= count_q + 3'd1;
      end
    end
  end

  assign rrx1     = ent_q[0];
  assign rrx2     = ent_q[1];
  assign rrx3     = ent_q[2];
  assign rrx4     = ent_q[3];
  assign rlss     = rlss_q;
  assign rr_valid = valid_q;
  assign rr_count = count_q;
  assign hit      = hit_q;
  assign alloc    = alloc_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_rr_alloc.sv
// Bench for rr_alloc: a reference model predicts the pulse and table
// outcome of every accepted request; predictions are queued at acceptance
// and compared one cycle (pulses) and two cycles (table) later.

module tb_rr_alloc;

  logic        clk = 1'b0;
  logic        rst, clear, np_valid, np_ready, np_local;
  logic [11:0] np_row, rrx1, rrx2, rrx3, rrx4;
  logic [3:0]  rlss, rr_valid;
  logic [2:0]  rr_count;
  logic        hit, alloc, fail;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_alloc dut (
    .clk(clk), .rst(rst), .clear(clear),
    .np_valid(np_valid), .np_ready(np_ready), .np_row(np_row), .np_local(np_local),
    .rrx1(rrx1), .rrx2(rrx2), .rrx3(rrx3), .rrx4(rrx4),
    .rlss(rlss), .rr_valid(rr_valid), .rr_count(rr_count),
    .hit(hit), .alloc(alloc), .fail(fail)
  );

  typedef struct packed {
    logic       h;
    logic       a;
    logic       f;
    logic [2:0] cnt_before;
  } pulse_t;

  typedef struct packed {
    logic [47:0] ents;
    logic [3:0]  rl;
    logic [3:0]  vl;
    logic [2:0]  cnt;
    logic        f;
  } tbl_t;

  pulse_t q_pulse[$];
  tbl_t   q_tbl[$];

  // reference model
  logic [11:0] m_ent [4];
  logic [3:0]  m_rl;
  int          m_cnt;
  logic        m_failst;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ent[i] = '0;
    m_rl     = '0;
    m_cnt    = 0;
    m_failst = 1'b0;
  endtask

  function automatic tbl_t model_tbl();
    tbl_t t;
    t.ents = {m_ent[3], m_ent[2], m_ent[1], m_ent[0]};
    t.rl   = m_rl;
    t.vl   = '0;
    for (int i = 0; i < 4; i++) if (i < m_cnt) t.vl[i] = 1'b1;
    t.cnt  = 3'(m_cnt);
    t.f    = m_failst;
    return t;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {rrx4, rrx3, rrx2, rrx1, rlss, rr_valid, rr_count, hit, alloc, fail}, 64'd0);
    chk({tag, "_ready"}, np_ready, 1'b1);
  endtask

  task automatic pop_tbl();
    tbl_t t;
    if (q_tbl.size() == 0) return;
    t = q_tbl.pop_front();
    chk("entries", {rrx4, rrx3, rrx2, rrx1}, t.ents);
    chk("rlss", rlss, t.rl);
    chk("rr_valid", rr_valid, t.vl);
    chk("rr_count", rr_count, t.cnt);
    chk("fail_tbl", fail, t.f);
  endtask

  // Called and returns at #1 after a rising edge.
  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; np_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_pulse.delete();
    q_tbl.delete();
    model_reset();
    chk_zero("reset");
  endtask

  task automatic send(input logic [11:0] row, input logic loc, input bit keep, output time t_acc);
    bit     accepted = 0;
    logic   exp_ready;
    logic   mt;
    pulse_t p;
    pulse_t got;
    np_valid = 1'b1; np_row = row; np_local = loc;
    for (int c = 0; c < 20 && !accepted; c++) begin
      if (np_ready === 1'b1) accepted = 1;
      @(posedge clk); #1;
    end
    t_acc = $time - 1;
    if (!accepted) begin
      chk("accept_timeout", 0, 1);
      np_valid = 1'b0;
      return;
    end
    if (!keep) np_valid = 1'b0;
    np_row   = 12'($urandom);
    np_local = 1'($urandom);
    pop_tbl();
    exp_ready = m_failst;
    chk("np_ready_after_accept", np_ready, exp_ready);
    p = '0;
    p.cnt_before = 3'(m_cnt);
    if (!m_failst) begin
      mt = 1'b0;
      for (int i = 0; i < m_cnt; i++)
        if (m_ent[i][9:0] == row[9:0] && (!m_rl[i] || m_ent[i][11:10] == row[11:10])) mt = 1'b1;
      if (mt) p.h = 1'b1;
      else if (m_cnt < 4) begin
        p.a = 1'b1;
        m_ent[m_cnt] = row;
        m_rl[m_cnt]  = loc;
        m_cnt++;
      end else m_failst = 1'b1;
    end
    p.f = m_failst;
    q_pulse.push_back(p);
    q_tbl.push_back(model_tbl());
    @(posedge clk); #1;
    got = q_pulse.pop_front();
    chk("hit", hit, got.h);
    chk("alloc", alloc, got.a);
    chk("fail", fail, got.f);
    chk("count_at_pulse", rr_count, got.cnt_before);
    if (!keep) begin
      @(posedge clk); #1;
      pop_tbl();
    end
  endtask

  time t1, t2, td;

  initial begin
    rst = 1'b1; clear = 1'b0; np_valid = 1'b0; np_row = '0; np_local = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("por");

    // local row, exact hit, then same addr in another block
    send(12'h123, 1'b1, 0, td);
    chk("rrx1_123", rrx1, 12'h123);
    chk("rlss_0001", rlss, 4'b0001);
    send(12'h123, 1'b0, 0, td);
    send(12'h923, 1'b0, 0, td);
    chk("rrx2_923", rrx2, 12'h923);

    // addr-only compare
    do_reset();
    send(12'h0AA, 1'b0, 0, td);
    send(12'hCAA, 1'b1, 0, td);
    chk("count_addr_only", rr_count, 3'd1);

    // fill, overflow, discard, clear
    do_reset();
    for (int i = 1; i <= 4; i++) send(12'(i), 1'($urandom), 0, td);
    send(12'h005, 1'b0, 0, td);
    send(12'h001, 1'b1, 0, td);
    chk("fail_sticky", fail, 1'b1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    chk_zero("clear");
    send(12'h055, 1'b0, 0, td);
    chk("alloc_after_clear", rrx1, 12'h055);

    // back-to-back with np_valid held
    do_reset();
    send(12'h010, 1'b0, 1, t1);
    send(12'h011, 1'b0, 0, t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'd20);
    chk("b2b_order", {rrx2, rrx1}, {12'h011, 12'h010});

    // reset during CHECK aborts the write
    do_reset();
    np_valid = 1'b1; np_row = 12'h3FF; np_local = 1'b1;
    @(posedge clk); #1;
    np_valid = 1'b0;
    chk("abort_in_check", np_ready, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_no_alloc", {hit, alloc}, 2'b00);
    @(posedge clk); #1;
    chk("abort_valid", rr_valid, 4'b0000);
    chk("abort_count", rr_count, 3'd0);
    model_reset();

    // random mix from a small row pool
    for (int i = 0; i < 16; i++)
      send({2'($urandom), 8'd0, 2'($urandom_range(0, 3))}, 1'($urandom), 0, td);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
